gr_arbiter: RTL and testbench

GR_ARBITER -- requirements
Module: gr_arbiter

---
 rtl/gr_arb_pkg.sv | 23 ++
 rtl/gr2.sv | 17 +
 rtl/gr_arbiter.sv | 167 ++++++++++++++++
 tb/tb_gr_arbiter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/gr_arb_pkg.sv
// Shared constants, FSM state encoding and small helpers for gr_arbiter.
// Only the four-requester, two-bit-priority configuration is supported.
package gr_arb_pkg;

    localparam int NREQ = 4;
    localparam int PW   = 2;
    localparam int IDXW = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_GRANT = 2'd2
    } gr_state_e;

    // Converts a requester index to its one-hot grant vector.
    function automatic logic [NREQ-1:0] idx_to_onehot(input logic [IDXW-1:0] idx);
        logic [NREQ-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/gr2.sv
// Two-bit unsigned magnitude comparator: agrb is high when a is strictly greater than b.
module gr2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       agrb
);

    logic msb_gt;
    logic msb_eq;
    logic lsb_gt;

    assign msb_gt = a[1] & ~b[1];
    assign msb_eq = ~(a[1] ^ b[1]);
    assign lsb_gt = a[0] & ~b[0];
    assign agrb   = msb_gt | (msb_eq & lsb_gt);

endmodule

// File: rtl/gr_arbiter.sv
// Sequential priority arbiter: snapshots requests, scans one requester per cycle
// through a single shared gr2 comparator, then holds a one-hot grant until release.
// Optional macro GR_ARB_RR_EN rotates the scan start past the last winner.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | waiting for any request; snapshot taken on leaving
//   ST_SCAN  | one candidate per cycle, four cycles, best kept in flops
//   ST_GRANT | one-hot grant held until the winner's live request drops
module gr_arbiter #(
    parameter int NREQ = gr_arb_pkg::NREQ,
    parameter int PW   = gr_arb_pkg::PW
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*PW-1:0]   prio,
    output logic [NREQ-1:0]      gnt,
    output logic                 busy
);

    import gr_arb_pkg::*;

    gr_state_e             state_q, state_d;
    logic [IDXW-1:0]       cnt_q, cnt_d;
    logic                  best_valid_q, best_valid_d;
    logic [IDXW-1:0]       best_idx_q, best_idx_d;
    logic [PW-1:0]         best_prio_q, best_prio_d;
    logic [NREQ-1:0]       req_snap_q, req_snap_d;
    logic [NREQ*PW-1:0]    prio_snap_q, prio_snap_d;
    logic [NREQ-1:0]       gnt_q, gnt_d;
    logic [IDXW-1:0]       win_idx_q, win_idx_d;

    logic [IDXW-1:0]       start_idx;
    logic [IDXW-1:0]       idx;
    logic [PW-1:0]         cand_prio;
    logic                  cand_gt;
    logic                  take;
    logic [IDXW-1:0]       final_idx;

`ifdef GR_ARB_RR_EN
    logic [IDXW-1:0]       last_win_q, last_win_d;

    assign start_idx = last_win_q + 2'd1;
`else
    assign start_idx = '0;
`endif

    assign idx = start_idx + cnt_q;

    always_comb begin
        cand_prio = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (idx == IDXW'(i)) begin
                cand_prio = prio_snap_q[i*PW +: PW];
            end
        end
    end

    // The only magnitude comparator; reused by every scan step.
    gr2 u_cmp (
        .a    (cand_prio),
        .b    (best_prio_q),
        .agrb (cand_gt)
    );

    // Strict greater-than means ties keep whichever requester was scanned first.
    assign take      = req_snap_q[idx] & (~best_valid_q | cand_gt);
    assign final_idx = take ? idx : best_idx_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        best_valid_d = best_valid_q;
        best_idx_d   = best_idx_q;
        best_prio_d  = best_prio_q;
        req_snap_d   = req_snap_q;
        prio_snap_d  = prio_snap_q;
        gnt_d        = gnt_q;
        win_idx_d    = win_idx_q;
`ifdef GR_ARB_RR_EN
        last_win_d   = last_win_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                gnt_d = '0;
                if (req != '0) begin
                    req_snap_d   = req;
                    prio_snap_d  = prio;
                    cnt_d        = '0;
                    best_valid_d = 1'b0;
                    state_d      = ST_SCAN;
                end
            end

            ST_SCAN: begin
                if (take) begin
                    best_valid_d = 1'b1;
                    best_idx_d   = idx;
                    best_prio_d  = cand_prio;
                end
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    gnt_d     = idx_to_onehot(final_idx);
                    win_idx_d = final_idx;
`ifdef GR_ARB_RR_EN
                    last_win_d = final_idx;
`endif
                    state_d   = ST_GRANT;
                end
            end

            ST_GRANT: begin
                // Release returns to IDLE only; a new snapshot waits one more edge.
                if (!req[win_idx_q]) begin
                    gnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            best_valid_q <= 1'b0;
            best_idx_q   <= '0;
            best_prio_q  <= '0;
            req_snap_q   <= '0;
            prio_snap_q  <= '0;
            gnt_q        <= '0;
            win_idx_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            best_valid_q <= best_valid_d;
            best_idx_q   <= best_idx_d;
            best_prio_q  <= best_prio_d;
            req_snap_q   <= req_snap_d;
            prio_snap_q  <= prio_snap_d;
            gnt_q        <= gnt_d;
            win_idx_q    <= win_idx_d;
        end
    end

`ifdef GR_ARB_RR_EN
    // Reset value 3 makes the first round after reset start its scan at requester 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_win_q <= 2'd3;
        end else begin
            last_win_q <= last_win_d;
        end
    end
`endif

    assign gnt  = gnt_q;
    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gr_arbiter.sv
// Self-checking bench for gr_arbiter: directed scenarios plus randomized rounds
// compared against a behavioural winner-selection model.
module tb_gr_arbiter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [7:0] prio = 8'h00;
    logic [3:0] gnt;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int model_last = 3;

    gr_arbiter #(.NREQ(4), .PW(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .prio    (prio),
        .gnt     (gnt),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_start();
`ifdef GR_ARB_RR_EN
        return (model_last + 1) % 4;
`else
        return 0;
`endif
    endfunction

    // Highest priority wins; among equals, the first in scan order from start.
    function automatic int ref_winner(input logic [3:0] r, input logic [7:0] p, input int start);
        int best = -1;
        int bp   = -1;
        for (int k = 0; k < 4; k++) begin
            int i = (start + k) % 4;
            if (r[i] && int'(p[2*i +: 2]) > bp) begin
                best = i;
                bp   = int'(p[2*i +: 2]);
            end
        end
        return best;
    endfunction

    // Called at a falling edge with the arbiter idle.
    task automatic do_round(input logic [3:0] r, input logic [7:0] p,
                            input bit perturb, input logic [3:0] r2, input logic [7:0] p2,
                            input bit drop_early);
        int w;
        logic [3:0] eg;
        logic [3:0] live;
        w    = ref_winner(r, p, model_start());
        eg   = 4'(1 << w);
        live = drop_early ? (r & ~eg) : r;
        req  = r;
        prio = p;
        @(posedge clk);
        @(negedge clk);
        check("snap_busy", busy, 1);
        check("snap_gnt", gnt, 0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("scan_gnt", gnt, 0);
            check("scan_busy", busy, 1);
            if (k == 1) begin
                if (perturb) begin
                    req  = r2;
                    prio = p2;
                end
                if (drop_early) req[w] = 1'b0;
            end
            if (k == 2) req = live;
        end
        @(posedge clk);
        @(negedge clk);
        check("grant", gnt, eg);
        check("grant_busy", busy, 1);
        model_last = w;
        if (!drop_early) begin
            repeat (2) begin
                @(posedge clk);
                @(negedge clk);
                check("hold", gnt, eg);
            end
            req[w] = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        check("rel_gnt", gnt, 0);
        check("rel_busy", busy, 0);
        req = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        check("idle_busy", busy, 0);
    endtask

    task automatic reset_mid(input logic [3:0] r, input logic [7:0] p, input bit in_grant);
        int w;
        logic [3:0] eg;
        w    = ref_winner(r, p, model_start());
        eg   = 4'(1 << w);
        req  = r;
        prio = p;
        repeat (3) @(posedge clk);
        @(negedge clk);
        if (in_grant) begin
            repeat (2) @(posedge clk);
            @(negedge clk);
            check("pre_rst_gnt", gnt, eg);
        end else begin
            check("pre_rst_busy", busy, 1);
        end
        #1 reset_n = 1'b0;
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_busy", busy, 0);
        req = 4'b0000;
        #1 reset_n = 1'b1;
        model_last = 3;
        @(negedge clk);
        check("post_rst_busy", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        check("reset_gnt", gnt, 0);
        check("reset_busy", busy, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        do_round(4'b0100, 8'b00_00_00_00, 1'b0, 4'b0, 8'h0, 1'b0);
        do_round(4'b1111, 8'b01_11_10_00, 1'b0, 4'b0, 8'h0, 1'b0);
        repeat (4) do_round(4'b1111, 8'b10_10_10_10, 1'b0, 4'b0, 8'h0, 1'b0);
        do_round(4'b0011, 8'b00_00_01_11, 1'b1, 4'b1011, 8'b00_00_11_11, 1'b0);
        reset_mid(4'b1111, 8'b01_11_10_00, 1'b0);
        do_round(4'b1111, 8'b01_11_10_00, 1'b0, 4'b0, 8'h0, 1'b0);
        reset_mid(4'b0110, 8'b00_01_10_00, 1'b1);
        do_round(4'b0110, 8'b00_01_10_00, 1'b0, 4'b0, 8'h0, 1'b0);
        do_round(4'b1000, 8'b11_00_00_00, 1'b0, 4'b0, 8'h0, 1'b1);

        for (int n = 0; n < 40; n++) begin
            logic [3:0] r;
            logic [7:0] p;
            logic [3:0] r2;
            logic [7:0] p2;
            r  = 4'($urandom_range(1, 15));
            p  = 8'($urandom);
            r2 = 4'($urandom);
            p2 = 8'($urandom);
            do_round(r, p, 1'($urandom_range(0, 1)), r2, p2, ($urandom_range(0, 4) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
